detect_sequence_prog: RTL and testbench

Parametrised, runtime-programmable serial sequence detector: next generation of the fixed 4-/6-bit shift-register detectors in the FSM exercise set. Accepts one valid-qualified bit per clock, compares the last W accepted bits against a loadable pattern with a per-bit don't-care mask, and supports overlapping and non-overlapping match modes. Emits a one-cycle `detected` pulse per match and keeps a saturating match count.

---
 rtl/detect_sequence_prog_if.sv | 27 ++
 rtl/detect_sequence_prog.sv | 72 +++++++
 tb/tb_detect_sequence_prog.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/detect_sequence_prog_if.sv
// Bit-stream, configuration and result signals of the programmable sequence detector.
// The master drives the stream and configuration; the detector (slave) drives the results.
interface detect_sequence_prog_if #(
  parameter int W     = 6,
  parameter int CNT_W = 8
);
  logic             new_bit_vld;
  logic             new_bit;
  logic             cfg_load;
  logic [W-1:0]     cfg_pattern;
  logic [W-1:0]     cfg_mask;
  logic             cfg_overlap;
  logic             clear;
  logic             detected;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output new_bit_vld, new_bit, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, clear,
    input  detected, match_cnt, cnt_sat
  );

  modport slave (
    input  new_bit_vld, new_bit, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, clear,
    output detected, match_cnt, cnt_sat
  );
endinterface

// File: rtl/detect_sequence_prog.sv
// Runtime-programmable serial sequence detector: masked compare of the last W accepted
// bits against a loadable pattern, overlapping or non-overlapping, with saturating count.
module detect_sequence_prog #(
  parameter int             W           = 6,
  parameter int             CNT_W       = 8,
  parameter logic [W-1:0]   RST_PATTERN = 6'b110011,
  parameter logic [W-1:0]   RST_MASK    = '1,
  parameter logic           RST_OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  detect_sequence_prog_if.slave bus
);
  localparam int             FW   = $clog2(W + 1);
  localparam logic [FW-1:0]  FULL = FW'(W);

  logic [W-1:0]     sh;
  logic [W-1:0]     pat;
  logic [W-1:0]     msk;
  logic             ovl;
  logic [FW-1:0]    fill;
  logic [CNT_W-1:0] cnt;
  logic             det;

  logic [W-1:0]     shifted;
  logic [FW-1:0]    fill_inc;
  logic             hit;
  logic             sat;

  // Fill gating keeps partial history (padded with flushed zeros) from ever matching.
  always_comb begin
    shifted  = {sh[W-2:0], bus.new_bit};
    fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
    hit      = (((shifted ^ pat) & msk) == '0) && (fill_inc == FULL);
  end

  assign sat = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      fill <= '0;
      det  <= 1'b0;
      cnt  <= '0;
      pat  <= RST_PATTERN;
      msk  <= RST_MASK;
      ovl  <= RST_OVERLAP;
    end else if (bus.clear || bus.cfg_load) begin
      sh   <= '0;
      fill <= '0;
      det  <= 1'b0;
      if (bus.clear) cnt <= '0;
      if (bus.cfg_load) begin
        pat <= bus.cfg_pattern;
        msk <= bus.cfg_mask;
        ovl <= bus.cfg_overlap;
      end
    end else if (bus.new_bit_vld) begin
      sh  <= shifted;
      det <= hit;
      // Non-overlapping mode needs W fresh bits before the next match.
      fill <= (hit && !ovl) ? '0 : fill_inc;
      if (hit && !sat) cnt <= cnt + 1'b1;
    end else begin
      det <= 1'b0;
    end
  end

  assign bus.detected  = det;
  assign bus.match_cnt = cnt;
  assign bus.cnt_sat   = sat;
endmodule

// File: tb/tb_detect_sequence_prog.sv
// Self-checking bench: table-driven reference stream, directed corner sequences and
// randomized traffic compared against a queue-based model of the detector.
module tb_detect_sequence_prog;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  detect_sequence_prog_if #(.W(W), .CNT_W(8)) bus ();
  detect_sequence_prog_if #(.W(W), .CNT_W(2)) bus2 ();

  detect_sequence_prog #(.W(W), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  detect_sequence_prog #(.W(W), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic b;
    logic exp_det;
    int   exp_cnt;
  } vec_t;
  vec_t tbl[24];
  logic [23:0] stream = 24'b0011_0101_1001_1001_1010_1000;

  // Reference model: history of accepted bits since the last flush / non-overlap match.
  bit         mq[$];
  logic [5:0] mpat, mmsk;
  bit         movl;
  int         mcnt;
  bit         mdet;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    mpat = 6'b110011;
    mmsk = 6'b111111;
    movl = 1'b1;
    mcnt = 0;
    mdet = 1'b0;
  endfunction

  function automatic bit model_match();
    int n = mq.size();
    if (n < W) return 1'b0;
    for (int i = 0; i < W; i++) begin
      // i = 0 is the oldest of the last W bits, compared against pattern bit W-1
      if (mmsk[W-1-i] && (mq[n-W+i] != mpat[W-1-i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_step();
    bit hit;
    if (bus.clear || bus.cfg_load) begin
      mq.delete();
      mdet = 1'b0;
      if (bus.clear) mcnt = 0;
      if (bus.cfg_load) begin
        mpat = bus.cfg_pattern;
        mmsk = bus.cfg_mask;
        movl = bus.cfg_overlap;
      end
    end else if (bus.new_bit_vld) begin
      mq.push_back(bus.new_bit);
      if (mq.size() > W) void'(mq.pop_front());
      hit  = model_match();
      mdet = hit;
      if (hit) begin
        if (mcnt < 255) mcnt++;
        if (!movl) mq.delete();
      end
    end else begin
      mdet = 1'b0;
    end
  endfunction

  // Apply one cycle on the main DUT and compare all outputs with the model.
  task automatic drive(input logic vld, input logic b, input logic clr, input logic ld);
    bus.new_bit_vld = vld;
    bus.new_bit     = b;
    bus.clear       = clr;
    bus.cfg_load    = ld;
    @(posedge clk);
    model_step();
    #1;
    bus.new_bit_vld = 1'b0;
    bus.clear       = 1'b0;
    bus.cfg_load    = 1'b0;
    check("detected", bus.detected, mdet);
    check("match_cnt", bus.match_cnt, mcnt);
    check("cnt_sat", bus.cnt_sat, mcnt == 255);
  endtask

  task automatic set_cfg(input logic [5:0] p, input logic [5:0] m, input logic o);
    bus.cfg_pattern = p;
    bus.cfg_mask    = m;
    bus.cfg_overlap = o;
  endtask

  task automatic play_stream(input bit gaps, output int pulses);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, stream[23-i], 1'b0, 1'b0);
      pulses += int'(bus.detected);
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          drive(1'b0, 1'($urandom), 1'b0, 1'b0);
          pulses += int'(bus.detected);
        end
      end
    end
  endtask

  task automatic drive2(input logic b, input logic clr, input logic exp_det, input int exp_cnt);
    bus2.new_bit_vld = 1'b1;
    bus2.new_bit     = b;
    bus2.clear       = clr;
    @(posedge clk);
    #1;
    bus2.new_bit_vld = 1'b0;
    bus2.clear       = 1'b0;
    check("sat_detected", bus2.detected, exp_det);
    check("sat_match_cnt", bus2.match_cnt, exp_cnt);
    check("sat_cnt_sat", bus2.cnt_sat, exp_cnt == 3);
  endtask

  initial begin
    int cnt_run;
    int pulses;

    cnt_run = 0;
    for (int i = 0; i < 24; i++) begin
      tbl[i].b       = stream[23-i];
      tbl[i].exp_det = (i == 12 || i == 16);
      if (tbl[i].exp_det) cnt_run++;
      tbl[i].exp_cnt = cnt_run;
    end

    bus.new_bit_vld = 0; bus.new_bit = 0; bus.clear = 0; bus.cfg_load = 0;
    set_cfg(6'b110011, 6'b111111, 1'b1);
    bus2.new_bit_vld = 0; bus2.new_bit = 0; bus2.clear = 0; bus2.cfg_load = 0;
    bus2.cfg_pattern = 6'b111111; bus2.cfg_mask = 6'b111111; bus2.cfg_overlap = 1'b1;
    model_reset();

    rst = 1'b1;
    #12;
    check("reset_detected", bus.detected, 0);
    check("reset_match_cnt", bus.match_cnt, 0);
    check("reset_cnt_sat", bus.cnt_sat, 0);
    @(negedge clk);
    rst = 1'b0;

    // Default configuration, overlapping: table of expected pulses
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, tbl[i].b, 1'b0, 1'b0);
      check("tbl_detected", bus.detected, tbl[i].exp_det);
      check("tbl_match_cnt", bus.match_cnt, tbl[i].exp_cnt);
    end

    // Non-overlapping: second occurrence suppressed; vld in the load cycle is dropped
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    set_cfg(6'b110011, 6'b111111, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    play_stream(1'b0, pulses);
    check("nonovl_pulses", pulses, 1);
    check("nonovl_cnt", bus.match_cnt, 1);

    // Overlapping again with random vld gaps
    set_cfg(6'b110011, 6'b111111, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    play_stream(1'b1, pulses);
    check("gaps_pulses", pulses, 2);
    check("gaps_cnt", bus.match_cnt, 2);

    // Partial mask: early occurrence at bit 3 gated by fill
    set_cfg(6'b110011, 6'b001111, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    play_stream(1'b0, pulses);
    check("mask_pulses", pulses, 2);
    check("mask_cnt", bus.match_cnt, 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation on the 2-bit counter instance
    bus2.cfg_load = 1'b1;
    @(posedge clk);
    #1;
    bus2.cfg_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive2(1'b1, 1'b0, i >= 5, (i >= 5) ? ((i - 4 > 3) ? 3 : i - 4) : 0);
    end
    drive2(1'b1, 1'b1, 1'b0, 0);

    // Mask all zeros matches every full-history bit; then async reset mid-stream
    set_cfg(6'b000000, 6'b000000, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 10; i++) drive(1'b1, stream[23-i], 1'b0, 1'b0);
    check("allmatch_cnt", bus.match_cnt, 8);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_detected", bus.detected, 0);
    check("async_rst_match_cnt", bus.match_cnt, 0);
    check("async_rst_cnt_sat", bus.cnt_sat, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    play_stream(1'b0, pulses);
    check("replay_pulses", pulses, 2);
    check("replay_cnt", bus.match_cnt, 2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) set_cfg(6'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b111111,
                         1'($urandom));
      drive(r < 75, 1'($urandom), r >= 97, r < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
